barrier_collision_ctrl: RTL and testbench

Frame-level controller sitting on the consuming side of the barrier sprite interface. It drives the barrier's `active` request and reads back its per-pixel hit flag and `in_position` status. While the barrier is armed, it counts pixels where the player and the barrier overlap and decides once per frame whether a collision occurred. It also tracks lives, dodges and spawn pacing for the game top level.

---
 rtl/barrier_collision_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_barrier_collision_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/barrier_collision_ctrl.sv
// Purpose : frame-level barrier controller: spawn pacing, overlap-based collision detection, lives/score.
// Latency : decisions on the v_sync rising-edge tick; all outputs registered, visible one cycle after the tick.
// Backpress: none; pixel samples are accepted on every i_pix_en cycle, i_start is a level request.
//
// Ports: i_clk/i_rst_n clock and async active-low reset; i_pix_en, i_player_hit, i_barrier_hit pixel samples;
//        i_v_sync frame sync; i_start start/restart; i_in_position barrier hittable status;
//        o_active barrier request; o_collision/o_dodged one-cycle pulses; o_flash post-hit window;
//        o_lives remaining lives; o_score saturating dodge count; o_game_over end-of-game flag.
module barrier_collision_ctrl #(
    parameter int SPAWN_GAP_FRAMES = 60,
    parameter int HIT_THRESH       = 16,
    parameter int LIVES            = 3,
    parameter int HIT_HOLD_FRAMES  = 30,
    parameter int ACTIVE_TIMEOUT   = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_pix_en,
    input  logic        i_v_sync,
    input  logic        i_start,
    input  logic        i_player_hit,
    input  logic        i_barrier_hit,
    input  logic        i_in_position,
    output logic        o_active,
    output logic        o_collision,
    output logic        o_dodged,
    output logic        o_flash,
    output logic [3:0]  o_lives,
    output logic [15:0] o_score,
    output logic        o_game_over
);

    typedef enum logic [2:0] {
        S_IDLE, S_GAP, S_ACTIVE, S_ARMED, S_HIT, S_GAMEOVER
    } state_t;

    localparam logic [15:0] GAP_L     = 16'(SPAWN_GAP_FRAMES);
    localparam logic [15:0] THRESH_L  = 16'(HIT_THRESH);
    localparam logic [15:0] HOLD_L    = 16'(HIT_HOLD_FRAMES);
    localparam logic [15:0] TIMEOUT_L = 16'(ACTIVE_TIMEOUT);
    localparam logic [3:0]  LIVES_L   = 4'(LIVES);

    state_t      r_state, w_state_nxt;
    logic        r_v_sync_q;
    logic [15:0] r_overlap;
    logic [15:0] r_frame_cnt, w_frame_nxt;
    logic [3:0]  r_lives, w_lives_nxt;
    logic [15:0] r_score, w_score_nxt;
    logic        r_collision, w_collision_nxt;
    logic        r_dodged, w_dodged_nxt;
    logic        r_active, r_flash, r_game_over;
    logic        w_tick, w_hit, w_retire;
    logic [15:0] w_frame_inc;

    assign w_tick      = i_v_sync & ~r_v_sync_q;
    assign w_frame_inc = r_frame_cnt + 16'd1;
    // r_overlap excludes the tick cycle's own pixel: it is cleared rather than incremented on the tick.
    assign w_hit       = (r_overlap >= THRESH_L);

    // Overlap counter: saturating, only meaningful while armed, restarted every frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v_sync_q <= 1'b0;
            r_overlap  <= 16'd0;
        end else begin
            r_v_sync_q <= i_v_sync;
            if (w_tick) begin
                r_overlap <= 16'd0;
            end else if ((r_state == S_ARMED) && i_pix_en && i_player_hit && i_barrier_hit
                         && (r_overlap != 16'hFFFF)) begin
                r_overlap <= r_overlap + 16'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_frame_cnt <= 16'd0;
            r_lives     <= LIVES_L;
            r_score     <= 16'd0;
            r_collision <= 1'b0;
            r_dodged    <= 1'b0;
            r_active    <= 1'b0;
            r_flash     <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_frame_cnt <= w_frame_nxt;
            r_lives     <= w_lives_nxt;
            r_score     <= w_score_nxt;
            r_collision <= w_collision_nxt;
            r_dodged    <= w_dodged_nxt;
            // Level outputs follow the next state so they line up with the state register.
            r_active    <= (w_state_nxt == S_ACTIVE) || (w_state_nxt == S_ARMED);
            r_flash     <= (w_state_nxt == S_HIT);
            r_game_over <= (w_state_nxt == S_GAMEOVER);
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_frame_nxt     = r_frame_cnt;
        w_lives_nxt     = r_lives;
        w_score_nxt     = r_score;
        w_collision_nxt = 1'b0;
        w_dodged_nxt    = 1'b0;
        w_retire        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_GAP;
                    w_lives_nxt = LIVES_L;
                    w_score_nxt = 16'd0;
                    w_frame_nxt = 16'd0;
                end
            end
            S_GAP: begin
                if (w_tick) begin
                    if (w_frame_inc >= GAP_L) begin
                        w_state_nxt = S_ACTIVE;
                        w_frame_nxt = 16'd0;
                    end else begin
                        w_frame_nxt = w_frame_inc;
                    end
                end
            end
            S_ACTIVE: begin
                // The frame count keeps running into ARMED so the timeout bounds the whole barrier lifetime.
                if (w_tick) begin
                    if (i_in_position) begin
                        w_state_nxt = S_ARMED;
                        w_frame_nxt = w_frame_inc;
                    end else if (w_frame_inc >= TIMEOUT_L) begin
                        w_retire = 1'b1;
                    end else begin
                        w_frame_nxt = w_frame_inc;
                    end
                end
            end
            S_ARMED: begin
                // Collision outranks both retire causes on the same tick.
                if (w_tick) begin
                    if (w_hit) begin
                        w_collision_nxt = 1'b1;
                        w_frame_nxt     = 16'd0;
                        if (r_lives <= 4'd1) begin
                            w_lives_nxt = 4'd0;
                            w_state_nxt = S_GAMEOVER;
                        end else begin
                            w_lives_nxt = r_lives - 4'd1;
                            w_state_nxt = S_HIT;
                        end
                    end else if (!i_in_position) begin
                        w_retire = 1'b1;
                    end else if (w_frame_inc >= TIMEOUT_L) begin
                        w_retire = 1'b1;
                    end else begin
                        w_frame_nxt = w_frame_inc;
                    end
                end
            end
            S_HIT: begin
                if (w_tick) begin
                    if (w_frame_inc >= HOLD_L) begin
                        w_state_nxt = S_GAP;
                        w_frame_nxt = 16'd0;
                    end else begin
                        w_frame_nxt = w_frame_inc;
                    end
                end
            end
            S_GAMEOVER: begin
                if (w_tick && i_start) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_retire) begin
            w_dodged_nxt = 1'b1;
            w_score_nxt  = (r_score == 16'hFFFF) ? r_score : r_score + 16'd1;
            w_state_nxt  = S_GAP;
            w_frame_nxt  = 16'd0;
        end
    end

    assign o_active    = r_active;
    assign o_collision = r_collision;
    assign o_dodged    = r_dodged;
    assign o_flash     = r_flash;
    assign o_lives     = r_lives;
    assign o_score     = r_score;
    assign o_game_over = r_game_over;

endmodule

// File: tb/tb_barrier_collision_ctrl.sv
// Purpose : directed self-checking bench for barrier_collision_ctrl with default parameters.
// Latency : each frame is 21 cycles; checks land on the falling edge right after the deciding tick.
// Backpress: not applicable; stimulus is driven on falling edges.
module tb_barrier_collision_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_pix_en = 1'b0;
    logic        i_v_sync = 1'b0;
    logic        i_start = 1'b0;
    logic        i_player_hit = 1'b0;
    logic        i_barrier_hit = 1'b0;
    logic        i_in_position = 1'b0;
    logic        o_active, o_collision, o_dodged, o_flash, o_game_over;
    logic [3:0]  o_lives;
    logic [15:0] o_score;

    int n_checks = 0;
    int n_fail   = 0;
    int n_coll   = 0;
    int n_dodge  = 0;

    barrier_collision_ctrl dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_pix_en      (i_pix_en),
        .i_v_sync      (i_v_sync),
        .i_start       (i_start),
        .i_player_hit  (i_player_hit),
        .i_barrier_hit (i_barrier_hit),
        .i_in_position (i_in_position),
        .o_active      (o_active),
        .o_collision   (o_collision),
        .o_dodged      (o_dodged),
        .o_flash       (o_flash),
        .o_lives       (o_lives),
        .o_score       (o_score),
        .o_game_over   (o_game_over)
    );

    always #5 i_clk = ~i_clk;

    // Pulse tally: a pulse stretched past one cycle would be counted twice.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_collision) n_coll++;
            if (o_dodged)    n_dodge++;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One frame: 20 pixel cycles (first ovl overlap, the rest player-only), then a one-cycle
    // v_sync high whose rising edge is the tick. Returns on the falling edge after the tick.
    task automatic run_frame(input int ovl, input bit inpos, input bit start_at_tick);
        i_in_position = inpos;
        for (int i = 0; i < 20; i++) begin
            i_v_sync      = 1'b0;
            i_pix_en      = 1'b1;
            i_player_hit  = 1'b1;
            i_barrier_hit = (i < ovl);
            @(negedge i_clk);
        end
        i_pix_en      = 1'b0;
        i_player_hit  = 1'b0;
        i_barrier_hit = 1'b0;
        i_v_sync      = 1'b1;
        i_start       = start_at_tick;
        @(negedge i_clk);
        i_v_sync = 1'b0;
        i_start  = 1'b0;
    endtask

    task automatic run_frames(input int n, input int ovl, input bit inpos);
        for (int f = 0; f < n; f++) run_frame(ovl, inpos, 1'b0);
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    initial begin
        // Reset held while v_sync toggles and start is requested.
        i_start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            i_v_sync = ~i_v_sync;
            @(negedge i_clk);
            @(negedge i_clk);
        end
        chk("rst_active", o_active, 0);
        chk("rst_coll", o_collision, 0);
        chk("rst_dodged", o_dodged, 0);
        chk("rst_flash", o_flash, 0);
        chk("rst_lives", o_lives, 3);
        chk("rst_score", o_score, 0);
        chk("rst_gameover", o_game_over, 0);
        i_start  = 1'b0;
        i_v_sync = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        run_frames(2, 0, 1'b0);
        chk("idle_active", o_active, 0);

        // Spawn pacing: active rises one cycle after the 60th tick.
        pulse_start();
        run_frames(59, 0, 1'b0);
        chk("gap59_active", o_active, 0);
        run_frame(0, 1'b0, 1'b0);
        chk("gap60_active", o_active, 1);

        // Dodge with 15 overlapping pixels per frame (one short of the threshold).
        run_frame(15, 1'b1, 1'b0);
        run_frame(15, 1'b1, 1'b0);
        chk("arm15_coll", o_collision, 0);
        chk("arm15_active", o_active, 1);
        run_frame(15, 1'b0, 1'b0);
        chk("dodge_pulse", o_dodged, 1);
        chk("dodge_coll", o_collision, 0);
        chk("dodge_score", o_score, 1);
        chk("dodge_active", o_active, 0);
        @(negedge i_clk);
        chk("dodge_width", o_dodged, 0);

        // Hit: 16 overlapping pixels in an armed frame.
        run_frames(60, 0, 1'b0);
        chk("hit_spawn", o_active, 1);
        run_frame(0, 1'b1, 1'b0);
        run_frame(16, 1'b1, 1'b0);
        chk("hit_pulse", o_collision, 1);
        chk("hit_lives", o_lives, 2);
        chk("hit_flash", o_flash, 1);
        chk("hit_active", o_active, 0);
        @(negedge i_clk);
        chk("hit_width", o_collision, 0);
        run_frames(29, 0, 1'b0);
        chk("hold29_flash", o_flash, 1);
        run_frame(0, 1'b0, 1'b0);
        chk("hold30_flash", o_flash, 0);

        // Priority: overlap >= threshold on the same tick in_position falls.
        run_frames(60, 0, 1'b0);
        run_frame(0, 1'b1, 1'b0);
        run_frame(18, 1'b0, 1'b0);
        chk("prio_coll", o_collision, 1);
        chk("prio_dodged", o_dodged, 0);
        chk("prio_lives", o_lives, 1);
        chk("prio_score", o_score, 1);
        run_frames(30, 0, 1'b0);

        // Timeout: never in position for 64 ticks.
        run_frames(60, 0, 1'b0);
        run_frames(63, 0, 1'b0);
        chk("to63_active", o_active, 1);
        chk("to63_dodged", o_dodged, 0);
        run_frame(0, 1'b0, 1'b0);
        chk("to64_dodged", o_dodged, 1);
        chk("to64_score", o_score, 2);
        chk("to64_active", o_active, 0);

        // Start is ignored in GAP.
        pulse_start();
        chk("gap_start_score", o_score, 2);
        chk("gap_start_lives", o_lives, 1);

        // Third hit ends the game.
        run_frames(60, 0, 1'b0);
        run_frame(0, 1'b1, 1'b0);
        run_frame(20, 1'b1, 1'b0);
        chk("go_coll", o_collision, 1);
        chk("go_lives", o_lives, 0);
        chk("go_flag", o_game_over, 1);
        chk("go_active", o_active, 0);

        // Start between ticks does nothing; start on a tick returns to IDLE.
        pulse_start();
        chk("go_start_notick", o_game_over, 1);
        run_frame(0, 1'b0, 1'b1);
        chk("go_idle_flag", o_game_over, 0);
        chk("go_idle_lives", o_lives, 0);
        pulse_start();
        chk("restart_lives", o_lives, 3);
        chk("restart_score", o_score, 0);

        chk("total_collisions", n_coll, 3);
        chk("total_dodges", n_dodge, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
